// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 FSM states, frame size and odd-parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} ps2_state_t;
  localparam int FRAME_BITS = 9;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes and glitch-filters the PS/2 clock, flags its falling edges
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic fall
);
  logic [1:0] sync;
  logic [FILTER_LEN-1:0] samples;
  logic level;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '1;
      samples <= '1;
      level   <= 1'b1;
    end else begin
      sync    <= {sync[0], ps2_clk};
      samples <= {samples[FILTER_LEN-2:0], sync[1]};
      level   <= &samples ? 1'b1 : ~|samples ? 1'b0 : level;
    end
  end
  assign fall = level & ~|samples;
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter with request-to-send, odd parity and timeout
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tx_en_i,
  input  logic [7:0] tx_data_i,
  inout  wire        ps2_clk_io,
  inout  wire        ps2_data_io,
  output logic       idle_o,
  output logic       done_o
);
  localparam int MAX_C = RTS_CYCLES > TIMEOUT_CYCLES ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  ps2_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FRAME_BITS-1:0] frame, frame_n;
  logic [3:0] idx, idx_n;
  logic fall, clk_low, data_low;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk_i),
    .rst(reset_i),
    .ps2_clk(ps2_clk_io),
    .fall(fall)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      frame <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      frame <= frame_n;
      idx   <= idx_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    frame_n = frame;
    idx_n   = idx;
    done_o  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_en_i) begin
          state_n = RTS;
          frame_n = {odd_parity(tx_data_i), tx_data_i};
        end
      end
      RTS: if (cnt == CW'(RTS_CYCLES - 1)) begin
        state_n = START;
        cnt_n   = '0;
      end
      default: begin
        if (fall) begin
          cnt_n = '0;
          if (state == START) begin
            state_n = DATA;
            idx_n   = '0;
          end else if (state == DATA) begin
            if (idx == 4'(FRAME_BITS - 1)) state_n = STOP;
            else begin
              frame_n = frame >> 1;
              idx_n   = idx + 1'b1;
            end
          end else begin
            state_n = IDLE;
            done_o  = 1'b1;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    endcase
  end
  assign idle_o      = state == IDLE;
  assign clk_low     = state == RTS;
  assign data_low    = state == START || (state == DATA && !frame[0]);
  assign ps2_clk_io  = clk_low ? 1'b0 : 1'bz;
  assign ps2_data_io = data_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: device-model bench for ps2_tx with table, random and corner-case frames
module tb_ps2_tx;
  localparam int RTS = 200;
  localparam int TMO = 500;
  localparam int H   = 30;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_en = 1'b0;
  logic [7:0] tx_data = '0;
  logic dev_clk_low = 1'b0;
  logic idle_o, done_o;
  wire ps2_clk, ps2_data;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk_i(clk),
    .reset_i(reset),
    .tx_en_i(tx_en),
    .tx_data_i(tx_data),
    .ps2_clk_io(ps2_clk),
    .ps2_data_io(ps2_data),
    .idle_o(idle_o),
    .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done_o) done_cnt++;
  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction
  task automatic start_tx(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_en = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_en = 1'b0;
    tx_data = 8'($urandom);
    check("idle_after_accept", 32'(idle_o), 0);
    n = 0;
    while (ps2_clk === 1'b0 && n < RTS + 50) begin
      n++;
      @(negedge clk);
    end
    check("rts_len", n, RTS);
    check("start_bit_at_release", 32'(ps2_data), 0);
  endtask
  task automatic run_frame(input logic [7:0] d, input int inject_at, input int reset_at,
                           output logic [10:0] got);
    int d0, m;
    got = '0;
    d0 = done_cnt;
    start_tx(d);
    for (int k = 0; k < 11; k++) begin
      repeat (H) @(negedge clk);
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_idle", 32'(idle_o), 1);
        check("rst_done", 32'(done_o), 0);
        check("rst_data_released", 32'(ps2_data), 1);
        check("rst_clk_released", 32'(ps2_clk), 1);
        return;
      end
      got[k] = ps2_data;
      dev_clk_low = 1'b1;
      if (k == inject_at) begin
        @(negedge clk);
        tx_en = 1'b1;
        tx_data = 8'hAA;
        @(negedge clk);
        tx_en = 1'b0;
      end
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    m = 0;
    while (!idle_o && m < 100) begin
      m++;
      @(negedge clk);
    end
    check("idle_after_frame", 32'(idle_o), 1);
    check("done_pulses", done_cnt - d0, 1);
    check("data_released_end", 32'(ps2_data), 1);
  endtask
  initial begin
    vec_t tbl[5];
    logic [10:0] got;
    logic [7:0] d;
    int n, d0;
    tbl = '{'{8'h55, 1'b1}, '{8'h00, 1'b1}, '{8'hFF, 1'b1}, '{8'h01, 1'b0}, '{8'h80, 1'b0}};
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_idle", 32'(idle_o), 1);
    check("reset_done", 32'(done_o), 0);
    check("reset_clk_line", 32'(ps2_clk), 1);
    check("reset_data_line", 32'(ps2_data), 1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || idle_o !== 1'b1 || done_o !== 1'b0) n++;
    end
    check("quiet_after_reset", n, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].d, -1, -1, got);
      check("tbl_start", 32'(got[0]), 0);
      check("tbl_byte", 32'(got[8:1]), 32'(tbl[i].d));
      check("tbl_parity", 32'(got[9]), 32'(tbl[i].par));
      check("tbl_stop", 32'(got[10]), 1);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      run_frame(d, -1, -1, got);
      check("rand_frame", 32'(got), 32'(model_frame(d)));
    end
    run_frame(8'h3C, 3, -1, got);
    check("busy_ignored", 32'(got), 32'(model_frame(8'h3C)));
    run_frame(8'hC3, -1, 5, got);
    run_frame(8'h5A, -1, -1, got);
    check("after_reset_frame", 32'(got), 32'(model_frame(8'h5A)));
    d0 = done_cnt;
    start_tx(8'h96);
    n = 0;
    while (!idle_o && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len", 32'(n >= TMO - 2 && n <= TMO + 2), 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_clk_released", 32'(ps2_clk), 1);
    check("timeout_data_released", 32'(ps2_data), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
